// File: rtl/vx_dispatch_unit_if.sv
// Dispatch-unit bus: issue-slot request streams in, lane-width execute packets out.
interface vx_dispatch_unit_if #(
   parameter int unsigned NUM_INPUTS  = 2,
   parameter int unsigned NUM_THREADS = 4,
   parameter int unsigned NUM_LANES   = 2,
   parameter int unsigned XLEN        = 32,
   parameter int unsigned META_W      = 64
);
   localparam int unsigned NUM_PACKETS = NUM_THREADS / NUM_LANES;
   localparam int unsigned PID_W       = (NUM_PACKETS > 1) ? $clog2(NUM_PACKETS) : 1;
   localparam int unsigned IN_W        = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

   logic [NUM_INPUTS-1:0]                  in_valid;
   logic [NUM_INPUTS*NUM_THREADS-1:0]      in_tmask;
   logic [NUM_INPUTS*NUM_THREADS*XLEN-1:0] in_rs1_data;
   logic [NUM_INPUTS*NUM_THREADS*XLEN-1:0] in_rs2_data;
   logic [NUM_INPUTS*NUM_THREADS*XLEN-1:0] in_rs3_data;
   logic [NUM_INPUTS*META_W-1:0]           in_meta;
   logic [NUM_INPUTS-1:0]                  in_ready;

   logic                      out_valid;
   logic                      out_ready;
   logic [IN_W-1:0]           out_isw;
   logic [NUM_LANES-1:0]      out_tmask;
   logic [NUM_LANES*XLEN-1:0] out_rs1_data;
   logic [NUM_LANES*XLEN-1:0] out_rs2_data;
   logic [NUM_LANES*XLEN-1:0] out_rs3_data;
   logic [META_W-1:0]         out_meta;
   logic [PID_W-1:0]          out_pid;
   logic                      out_sop;
   logic                      out_eop;

   modport master (
      output in_valid, in_tmask, in_rs1_data, in_rs2_data, in_rs3_data, in_meta,
      input  in_ready,
      input  out_valid, out_isw, out_tmask, out_rs1_data, out_rs2_data, out_rs3_data,
      input  out_meta, out_pid, out_sop, out_eop,
      output out_ready
   );

   modport slave (
      input  in_valid, in_tmask, in_rs1_data, in_rs2_data, in_rs3_data, in_meta,
      output in_ready,
      output out_valid, out_isw, out_tmask, out_rs1_data, out_rs2_data, out_rs3_data,
      output out_meta, out_pid, out_sop, out_eop,
      input  out_ready
   );
endinterface

// File: rtl/vx_dispatch_unit.sv
// Round-robin issue-slot arbiter that serializes the granted warp request into
// lane-width packets, skipping packets with no active threads.
module vx_dispatch_unit #(
   parameter int unsigned NUM_INPUTS  = 2,
   parameter int unsigned NUM_THREADS = 4,
   parameter int unsigned NUM_LANES   = 2,
   parameter int unsigned XLEN        = 32,
   parameter int unsigned META_W      = 64
) (
   input logic               clk,
   input logic               reset,
   vx_dispatch_unit_if.slave bus
);
   localparam int unsigned NUM_PACKETS = NUM_THREADS / NUM_LANES;
   localparam int unsigned PID_W       = (NUM_PACKETS > 1) ? $clog2(NUM_PACKETS) : 1;
   localparam int unsigned IN_W        = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
   localparam int unsigned LANE_W      = NUM_LANES * XLEN;

   typedef enum logic [0:0] {IDLE, LOCK} state_t;

   state_t           state, state_nxt;
   logic [IN_W-1:0]  rr_ptr, rr_nxt;
   logic [IN_W-1:0]  lock_idx, lock_nxt;
   logic [PID_W-1:0] cur_pid, pid_nxt;

   logic [NUM_LANES-1:0] tm_a   [NUM_INPUTS][NUM_PACKETS];
   logic [LANE_W-1:0]    rs1_a  [NUM_INPUTS][NUM_PACKETS];
   logic [LANE_W-1:0]    rs2_a  [NUM_INPUTS][NUM_PACKETS];
   logic [LANE_W-1:0]    rs3_a  [NUM_INPUTS][NUM_PACKETS];
   logic [META_W-1:0]    meta_a [NUM_INPUTS];

   logic                   arb_valid, gnt_valid;
   logic [IN_W-1:0]        arb_idx, gnt_idx;
   logic [NUM_PACKETS-1:0] act;
   logic [PID_W-1:0]       sel_pid;
   logic                   sel_eop;
   logic                   load, advance, eop_adv;
   logic [NUM_INPUTS-1:0]  in_ready_c;

   function automatic logic [IN_W-1:0] wrap_idx(input logic [IN_W-1:0] base, input int unsigned off);
      return IN_W'((32'(base) + off) % NUM_INPUTS);
   endfunction

   // Reshape flat input buses into per-slot, per-packet views
   for (genvar s = 0; s < NUM_INPUTS; s++) begin : g_slot
      assign meta_a[s] = bus.in_meta[s*META_W +: META_W];
      for (genvar p = 0; p < NUM_PACKETS; p++) begin : g_pkt
         localparam int unsigned T0 = s*NUM_THREADS + p*NUM_LANES;
         assign tm_a[s][p]  = bus.in_tmask[T0 +: NUM_LANES];
         assign rs1_a[s][p] = bus.in_rs1_data[T0*XLEN +: LANE_W];
         assign rs2_a[s][p] = bus.in_rs2_data[T0*XLEN +: LANE_W];
         assign rs3_a[s][p] = bus.in_rs3_data[T0*XLEN +: LANE_W];
      end
   end

   // Lowest valid slot at or after the round-robin pointer
   always_comb begin
      arb_valid = 1'b0;
      arb_idx   = '0;
      for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
         if (!arb_valid && bus.in_valid[wrap_idx(rr_ptr, i)]) begin
            arb_valid = 1'b1;
            arb_idx   = wrap_idx(rr_ptr, i);
         end
      end
   end

   assign gnt_idx   = (state == LOCK) ? lock_idx : arb_idx;
   assign gnt_valid = (state == LOCK) ? bus.in_valid[lock_idx] : arb_valid;

   // Packet selection: first active packet on a fresh request, next active one above cur_pid when locked
   always_comb begin
      act     = '0;
      sel_pid = '0;
      sel_eop = 1'b1;
      for (int p = 0; p < int'(NUM_PACKETS); p++) begin
         act[p] = |tm_a[gnt_idx][p];
      end
      for (int p = int'(NUM_PACKETS) - 1; p >= 0; p--) begin
         if (act[p] && (state == IDLE || p > int'(cur_pid))) sel_pid = PID_W'(p);
      end
      for (int p = 0; p < int'(NUM_PACKETS); p++) begin
         if (act[p] && p > int'(sel_pid)) sel_eop = 1'b0;
      end
   end

   assign load    = !bus.out_valid || bus.out_ready;
   assign advance = load && gnt_valid;
   assign eop_adv = advance && sel_eop;

   always_comb begin
      in_ready_c = '0;
      for (int unsigned s = 0; s < NUM_INPUTS; s++) begin
         in_ready_c[s] = reset && eop_adv && (gnt_idx == IN_W'(s));
      end
   end
   assign bus.in_ready = in_ready_c;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         rr_ptr   <= '0;
         lock_idx <= '0;
         cur_pid  <= '0;
      end else begin
         state    <= state_nxt;
         rr_ptr   <= rr_nxt;
         lock_idx <= lock_nxt;
         cur_pid  <= pid_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      rr_nxt    = rr_ptr;
      lock_nxt  = lock_idx;
      pid_nxt   = cur_pid;
      case (state)
         IDLE: begin
            if (advance && !sel_eop) begin
               state_nxt = LOCK;
               lock_nxt  = gnt_idx;
            end
         end
         LOCK: begin
            if (eop_adv) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (advance) pid_nxt = sel_pid;
      if (eop_adv) rr_nxt = wrap_idx(gnt_idx, 1);
   end

   // Output packet register; data holds while stalled or when no packet is selected
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.out_valid    <= 1'b0;
         bus.out_isw      <= '0;
         bus.out_tmask    <= '0;
         bus.out_rs1_data <= '0;
         bus.out_rs2_data <= '0;
         bus.out_rs3_data <= '0;
         bus.out_meta     <= '0;
         bus.out_pid      <= '0;
         bus.out_sop      <= 1'b0;
         bus.out_eop      <= 1'b0;
      end else if (load) begin
         bus.out_valid <= gnt_valid;
         if (gnt_valid) begin
            bus.out_isw      <= gnt_idx;
            bus.out_tmask    <= tm_a[gnt_idx][sel_pid];
            bus.out_rs1_data <= rs1_a[gnt_idx][sel_pid];
            bus.out_rs2_data <= rs2_a[gnt_idx][sel_pid];
            bus.out_rs3_data <= rs3_a[gnt_idx][sel_pid];
            bus.out_meta     <= meta_a[gnt_idx];
            bus.out_pid      <= sel_pid;
            bus.out_sop      <= (state == IDLE);
            bus.out_eop      <= sel_eop;
         end
      end
   end

`ifndef SYNTHESIS
   // Upstream must hold a locked request until its eop packet is accepted
   always @(posedge clk) begin
      if (reset && state == LOCK) begin
         assert (bus.in_valid[lock_idx])
         else $error("vx_dispatch_unit: slot %0d dropped in_valid mid-request", lock_idx);
      end
   end
`endif

endmodule

// File: tb/tb_vx_dispatch_unit.sv
// Directed bench for vx_dispatch_unit: a 2-lane instance (serializing) and a
// 4-lane instance (pure registered arbiter) share clock and reset.
module tb_vx_dispatch_unit;
   localparam int unsigned NI = 2;
   localparam int unsigned NT = 4;
   localparam int unsigned XL = 32;
   localparam int unsigned MW = 64;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   vx_dispatch_unit_if #(.NUM_INPUTS(NI), .NUM_THREADS(NT), .NUM_LANES(2), .XLEN(XL), .META_W(MW)) bus ();
   vx_dispatch_unit_if #(.NUM_INPUTS(NI), .NUM_THREADS(NT), .NUM_LANES(4), .XLEN(XL), .META_W(MW)) bus4 ();

   vx_dispatch_unit #(.NUM_INPUTS(NI), .NUM_THREADS(NT), .NUM_LANES(2), .XLEN(XL), .META_W(MW)) dut (
      .clk(clk), .reset(reset), .bus(bus.slave)
   );
   vx_dispatch_unit #(.NUM_INPUTS(NI), .NUM_THREADS(NT), .NUM_LANES(4), .XLEN(XL), .META_W(MW)) dut4 (
      .clk(clk), .reset(reset), .bus(bus4.slave)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Registered-output snapshot of the 2-lane instance
   task automatic check_pkt(input string tag, input logic [1:0] isw_pid, input logic [1:0] sop_eop,
                            input logic [1:0] tmask, input logic [63:0] rs1);
      check({tag, ".valid"}, 128'(bus.out_valid), 128'(1));
      check({tag, ".isw"},   128'(bus.out_isw),   128'(isw_pid[1]));
      check({tag, ".pid"},   128'(bus.out_pid),   128'(isw_pid[0]));
      check({tag, ".sop"},   128'(bus.out_sop),   128'(sop_eop[1]));
      check({tag, ".eop"},   128'(bus.out_eop),   128'(sop_eop[0]));
      check({tag, ".tmask"}, 128'(bus.out_tmask), 128'(tmask));
      check({tag, ".rs1"},   128'(bus.out_rs1_data), 128'(rs1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.in_valid  = '0;  bus.in_tmask  = '0;  bus.out_ready  = 1'b1;
      bus4.in_valid = '0;  bus4.in_tmask = '0;  bus4.out_ready = 1'b1;
      for (int s = 0; s < int'(NI); s++) begin
         for (int t = 0; t < int'(NT); t++) begin
            bus.in_rs1_data[(s*NT+t)*XL +: XL]  = 32'h1000_0000 + 32'(s*256 + t);
            bus.in_rs2_data[(s*NT+t)*XL +: XL]  = 32'h2000_0000 + 32'(s*256 + t);
            bus.in_rs3_data[(s*NT+t)*XL +: XL]  = 32'h3000_0000 + 32'(s*256 + t);
            bus4.in_rs1_data[(s*NT+t)*XL +: XL] = 32'h1000_0000 + 32'(s*256 + t);
            bus4.in_rs2_data[(s*NT+t)*XL +: XL] = 32'h2000_0000 + 32'(s*256 + t);
            bus4.in_rs3_data[(s*NT+t)*XL +: XL] = 32'h3000_0000 + 32'(s*256 + t);
         end
      end
      bus.in_meta  = {64'hCAFE_0000_0000_0001, 64'hCAFE_0000_0000_0000};
      bus4.in_meta = {64'hCAFE_0000_0000_0001, 64'hCAFE_0000_0000_0000};

      // Reset state
      tick(); tick();
      check("rst.out_valid", 128'(bus.out_valid), 128'(0));
      check("rst.out_tmask", 128'(bus.out_tmask), 128'(0));
      check("rst.out_pid",   128'(bus.out_pid),   128'(0));
      check("rst.out_meta",  128'(bus.out_meta),  128'(0));
      check("rst.out_rs1",   128'(bus.out_rs1_data), 128'(0));
      bus.in_valid = 2'b01; bus.in_tmask = 8'b0000_0011;
      #1 check("rst.in_ready", 128'(bus.in_ready), 128'(0));
      bus.in_valid = 2'b00;
      reset = 1'b1;
      tick();

      // Full mask on slot0: two packets, in_ready only with pid1
      bus.in_tmask = 8'b0000_1111; bus.in_valid = 2'b01;
      #1 check("full.rdy0", 128'(bus.in_ready), 128'(2'b00));
      tick();
      check_pkt("full.p0", 2'b00, 2'b10, 2'b11, {32'h1000_0001, 32'h1000_0000});
      check("full.meta", 128'(bus.out_meta), 128'(64'hCAFE_0000_0000_0000));
      check("full.rdy1", 128'(bus.in_ready), 128'(2'b01));
      tick();
      check_pkt("full.p1", 2'b01, 2'b01, 2'b11, {32'h1000_0003, 32'h1000_0002});
      check("full.rs3", 128'(bus.out_rs3_data), 128'({32'h3000_0003, 32'h3000_0002}));
      bus.in_valid = 2'b00;
      #1 check("full.rdy_idle", 128'(bus.in_ready), 128'(2'b00));
      tick();
      check("full.drop", 128'(bus.out_valid), 128'(0));

      // Upper-half mask: single packet pid1
      bus.in_tmask = 8'b0000_1100; bus.in_valid = 2'b01;
      #1 check("hi.rdy", 128'(bus.in_ready), 128'(2'b01));
      tick();
      check_pkt("hi", 2'b01, 2'b11, 2'b11, {32'h1000_0003, 32'h1000_0002});
      check("hi.rs2", 128'(bus.out_rs2_data), 128'({32'h2000_0003, 32'h2000_0002}));

      // All-zero mask: one empty packet pid0
      bus.in_tmask = 8'b0000_0000;
      #1 check("zero.rdy", 128'(bus.in_ready), 128'(2'b01));
      tick();
      check_pkt("zero", 2'b00, 2'b11, 2'b00, {32'h1000_0001, 32'h1000_0000});
      bus.in_valid = 2'b00;

      // Both slots continuously valid; pointer sits at 1 after slot0's last eop
      bus.in_tmask = 8'b0011_0011; bus.in_valid = 2'b11;
      for (int k = 0; k < 4; k++) begin
         logic s;
         s = (k % 2 == 0);
         #1 check("alt.rdy", 128'(bus.in_ready), 128'(s ? 2'b10 : 2'b01));
         tick();
         check_pkt("alt", {s, 1'b0}, 2'b11, 2'b11,
                   s ? {32'h1000_0101, 32'h1000_0100} : {32'h1000_0001, 32'h1000_0000});
      end
      bus.in_valid = 2'b00;

      // Async reset between pid0 and pid1 of slot1's request
      bus.in_tmask = 8'b1111_1111; bus.in_valid = 2'b11;
      tick();
      check_pkt("prerst", 2'b10, 2'b10, 2'b11, {32'h1000_0101, 32'h1000_0100});
      #3 reset = 1'b0;
      #1 check("midrst.valid", 128'(bus.out_valid), 128'(0));
      check("midrst.rdy", 128'(bus.in_ready), 128'(2'b00));
      tick(); tick();
      reset = 1'b1;
      #1 check("postrst.rdy", 128'(bus.in_ready), 128'(2'b00));
      tick();
      check_pkt("postrst.p0", 2'b00, 2'b10, 2'b11, {32'h1000_0001, 32'h1000_0000});
      check("postrst.rdy1", 128'(bus.in_ready), 128'(2'b01));
      tick();
      check_pkt("postrst.p1", 2'b01, 2'b01, 2'b11, {32'h1000_0003, 32'h1000_0002});
      bus.in_valid = 2'b10;
      #1 check("s1.rdy0", 128'(bus.in_ready), 128'(2'b00));
      tick();
      check_pkt("s1.p0", 2'b10, 2'b10, 2'b11, {32'h1000_0101, 32'h1000_0100});
      check("s1.rdy1", 128'(bus.in_ready), 128'(2'b10));
      tick();
      check_pkt("s1.p1", 2'b11, 2'b01, 2'b11, {32'h1000_0103, 32'h1000_0102});
      bus.in_valid = 2'b00;

      // Downstream stall during pid0; slot1 shows up mid-request
      bus.in_tmask = 8'b0011_1111; bus.in_valid = 2'b01;
      tick();
      check_pkt("stall.p0", 2'b00, 2'b10, 2'b11, {32'h1000_0001, 32'h1000_0000});
      bus.out_ready = 1'b0; bus.in_valid = 2'b11;
      for (int k = 0; k < 5; k++) begin
         #1 check("stall.rdy", 128'(bus.in_ready), 128'(2'b00));
         tick();
         check_pkt("stall.hold", 2'b00, 2'b10, 2'b11, {32'h1000_0001, 32'h1000_0000});
      end
      bus.out_ready = 1'b1;
      #1 check("stall.rel_rdy", 128'(bus.in_ready), 128'(2'b01));
      tick();
      check_pkt("stall.p1", 2'b01, 2'b01, 2'b11, {32'h1000_0003, 32'h1000_0002});
      bus.in_valid = 2'b10;
      #1 check("stall.s1_rdy", 128'(bus.in_ready), 128'(2'b10));
      tick();
      check_pkt("stall.s1", 2'b10, 2'b11, 2'b11, {32'h1000_0101, 32'h1000_0100});
      bus.in_valid = 2'b00;
      tick();
      check("stall.drop", 128'(bus.out_valid), 128'(0));

      // Four-lane instance: one packet per request, one request per cycle
      bus4.in_tmask = 8'b0101_1111; bus4.in_valid = 2'b11;
      for (int k = 0; k < 4; k++) begin
         logic s;
         s = (k % 2 == 1);
         #1 check("l4.rdy", 128'(bus4.in_ready), 128'(s ? 2'b10 : 2'b01));
         tick();
         check("l4.valid", 128'(bus4.out_valid), 128'(1));
         check("l4.isw",   128'(bus4.out_isw),   128'(s));
         check("l4.pid",   128'(bus4.out_pid),   128'(0));
         check("l4.sop",   128'(bus4.out_sop),   128'(1));
         check("l4.eop",   128'(bus4.out_eop),   128'(1));
         check("l4.tmask", 128'(bus4.out_tmask), 128'(s ? 4'b0101 : 4'b1111));
         check("l4.rs1",   bus4.out_rs1_data,
               s ? {32'h1000_0103, 32'h1000_0102, 32'h1000_0101, 32'h1000_0100}
                 : {32'h1000_0003, 32'h1000_0002, 32'h1000_0001, 32'h1000_0000});
      end
      bus4.in_valid = 2'b00;
      tick();
      check("l4.drop", 128'(bus4.out_valid), 128'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/vx_dispatch_unit.md
Name: VX_dispatch_unit

Overview:
- Per-execution-unit front end directly downstream of the dispatch buffers. It takes NUM_INPUTS issue-slot dispatch streams, each carrying NUM_THREADS-wide operands.
- A round-robin arbiter picks one slot. The block then serializes the selected request into lane-width packets of NUM_LANES threads for the execute unit. Packets with no active threads are skipped.
- Each packet is tagged with packet id, start-of-packet (sop) and end-of-packet (eop).
- The output is registered and feeds ALU/LSU/FPU/SFU lane datapaths.

Parameters:
- NUM_INPUTS, 2, number of issue slots feeding this unit (ISSUE_WIDTH).
- NUM_THREADS, 4, threads per warp request.
- NUM_LANES, 2, execute lanes. Must divide NUM_THREADS.
- XLEN, 32, operand width.
- META_W, 64, opaque per-request payload (uuid, wis, op, mod, PC, rd, wb, tid), forwarded unchanged.
- Derived: NUM_PACKETS = NUM_THREADS/NUM_LANES; PID_W = max(1, clog2(NUM_PACKETS)); IN_W = max(1, clog2(NUM_INPUTS)).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- in_valid  in  NUM_INPUTS  per-slot request valid.
- in_tmask  in  NUM_INPUTS*NUM_THREADS  per-slot thread mask.
- in_rs1_data, in_rs2_data, in_rs3_data  in  NUM_INPUTS*NUM_THREADS*XLEN  operands.
- in_meta  in  NUM_INPUTS*META_W  payload.
- in_ready  out  NUM_INPUTS  per-slot accept.
- out_valid  out  1  packet valid.
- out_ready  in  1  downstream accept.
- out_isw  out  IN_W  source slot index.
- out_tmask  out  NUM_LANES  lane mask.
- out_rs1_data, out_rs2_data, out_rs3_data  out  NUM_LANES*XLEN  lane operands.
- out_meta  out  META_W  payload.
- out_pid  out  PID_W  packet id.
- out_sop  out  1  first packet of request.
- out_eop  out  1  last packet of request.

Behaviour:
- Reset (asynchronous, reset=0):
  - out_valid=0 and all out_* data=0.
  - in_ready=0.
  - rr pointer=0, state=IDLE, pid=0, sop_pending=1.
- Output register: loads when (!out_valid || out_ready). "Advance" means a load occurs with a packet selected. Latency from in_valid to out_valid is 1 cycle minimum.
- Handshake:
  - out_valid/data hold stable while out_valid && !out_ready.
  - Inputs must hold valid and data until in_ready. A drop mid-request is a protocol violation, flagged by a simulation assertion.
- State IDLE:
  - Arbiter grants the lowest valid index at or after the rr pointer, wrapping.
  - Grant is combinational from in_valid. Nothing is granted if all in_valid=0.
- State LOCK: the grant index is held in a register until that request's eop packet advances. No re-arbitration happens while locked.
- Packet selection: packet p covers threads [p*NUM_LANES, (p+1)*NUM_LANES). Active packets are those with a nonzero tmask slice.
  - First emitted pid = lowest active packet.
  - Next pid = next active packet above current.
  - eop = 1 when no higher active packet exists.
  - sop = 1 on the first emitted packet only.
- All-zero tmask: one packet is emitted with pid=0, tmask=0, sop=eop=1.
- NUM_PACKETS=1: pure registered arbiter. Every packet has sop=eop=1 and pid=0. No LOCK dwell.
- in_ready[g]=1 only in the cycle the eop packet of granted slot g advances. All other bits are 0.
- Transitions:
  - IDLE→LOCK when a grant advances a non-eop packet.
  - IDLE stays IDLE when the granted packet is also eop.
  - LOCK→IDLE when the eop packet advances.
  - On eop advance, rr pointer ← grant+1 mod NUM_INPUTS.
- Simultaneous events: a new request may be granted in the same cycle the eop packet advances. Back-to-back requests have no bubble.
- out_valid drops only when no packet is selected at a load.
- Downstream stall: the output register holds and pid does not advance. The locked slot stays locked, other slots wait, and in_ready stays 0.
- Reset mid-request: any in-flight packet is discarded and in_ready stays 0. The upstream request remains pending and re-issues from sop after reset.

Test Plan:
- NUM_THREADS=4, NUM_LANES=2: slot0 valid, tmask=4'b1111, out_ready=1 → two packets on consecutive cycles: pid0 (sop=1, eop=0, tmask=2'b11), then pid1 (sop=0, eop=1). in_ready[0]=1 only in the cycle pid1 advances.
- tmask=4'b1100 → single packet pid=1, sop=eop=1, lanes carry threads 2,3 data. tmask=4'b0000 → single packet pid=0, tmask=0, sop=eop=1.
- Slots 0 and 1 both valid continuously, tmask=4'b0011 → grants alternate 0,1,0,1 with out_isw toggling every cycle and no bubbles.
- Hold out_ready=0 for 5 cycles during pid0 of a 2-packet request → out_* stable and in_ready=0 throughout. Release → pid1 is emitted next and slot1 is not granted mid-request.
- Assert reset=0 asynchronously between pid0 and pid1 → out_valid falls immediately. After release, the request restarts with pid0, sop=1, and rr pointer=0.
- NUM_LANES=NUM_THREADS=4 → every output has sop=eop=1 and pid=0, with throughput 1 request/cycle under out_ready=1.
